// File: rtl/gemv_mac_scheduler.sv
// gemv_mac_scheduler
//   Computes y = A * x one row at a time on a shared LANES-wide signed
//   multiply-accumulate datapath. The N-element vector x is buffered first,
//   then each row of A streams in as N/LANES beats of LANES elements. Each
//   row's dot product leaves as one result on a valid/ready port.
//
// Ports
//   clk, rst_n        : single clock, synchronous active-low reset
//   start             : job start pulse, looked at in IDLE only
//   cfg_rows          : rows in the job (0 finishes at once), latched on start
//   keep_vec          : reuse the stored vector, latched on start
//   vec_valid/ready   : vector element stream, elements in index order 0..N-1
//   vec_data          : signed vector element
//   mat_valid/ready   : matrix beat stream; lane j = bits [j*DATA_W +: DATA_W]
//                       and beat b carries row elements b*LANES+j
//   res_valid/ready   : result stream, rows in order 0..cfg_rows-1
//   res_data          : signed dot product (modulo 2^ACC_W, no saturation)
//   res_row           : row index of res_data
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse at the end of a job
//
// Handshake rule for all three streams: a transfer happens on a rising edge
// where valid and ready are both high. A producer holds valid and data
// steady until that edge; ready may be given or withdrawn at any time.
//
// The FSM state is held in the enum signal `state` (IDLE, LOAD_VEC,
// ROW_MAC, DRAIN, DONE) for observation by checkers.

module gemv_mac_scheduler #(
  parameter int DATA_W   = 16,
  parameter int N        = 32,
  parameter int LANES    = 4,
  parameter int ROWS_MAX = 64,
  parameter int ACC_W    = 40
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [$clog2(ROWS_MAX+1)-1:0]       cfg_rows,
  input  logic                                keep_vec,
  input  logic                                vec_valid,
  output logic                                vec_ready,
  input  logic signed [DATA_W-1:0]            vec_data,
  input  logic                                mat_valid,
  output logic                                mat_ready,
  input  logic [LANES*DATA_W-1:0]             mat_data,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic signed [ACC_W-1:0]             res_data,
  output logic [$clog2(ROWS_MAX)-1:0]         res_row,
  output logic                                busy,
  output logic                                done
);

  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(ROWS_MAX + 1);
  localparam int RROW_W = $clog2(ROWS_MAX);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_VEC = 3'd1,
    ROW_MAC  = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state;
  state_t state_d;

  // Vector store and job bookkeeping
  logic signed [DATA_W-1:0] vec_buf [N];
  logic [VIDX_W-1:0]        vec_idx;
  logic                     vec_loaded;
  logic [CNT_W-1:0]         rows_q;
  logic [CNT_W-1:0]         row_cnt;
  logic [BEAT_W-1:0]        beat_cnt;

  // Stage 1: registered lane products
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;
  logic [RROW_W-1:0]        s1_row;
  logic signed [PROD_W-1:0] s1_prod [LANES];

  // Stage 2: running accumulator
  logic signed [ACC_W-1:0]  acc;

  logic                     en;
  logic                     vec_fire;
  logic                     mat_fire;
  logic                     last_beat;
  logic                     last_row;
  logic                     job_start;

  logic signed [DATA_W-1:0] mat_lane [LANES];
  logic signed [DATA_W-1:0] vec_op   [LANES];
  logic signed [PROD_W-1:0] prod     [LANES];
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_next;

  // A result parked at the output (valid but not taken) freezes both
  // pipeline stages and the matrix input.
  assign en        = !(res_valid && !res_ready);
  assign vec_ready = (state == LOAD_VEC);
  assign mat_ready = (state == ROW_MAC) && en;
  assign vec_fire  = vec_valid && vec_ready;
  assign mat_fire  = mat_valid && mat_ready;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign last_row  = (row_cnt == rows_q - CNT_W'(1));
  assign job_start = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_rows == '0)             state_d = DONE;
          else if (keep_vec && vec_loaded) state_d = ROW_MAC;
          else                             state_d = LOAD_VEC;
        end
      end
      LOAD_VEC: if (vec_fire && vec_idx == VIDX_W'(N - 1)) state_d = ROW_MAC;
      ROW_MAC:  if (mat_fire && last_beat && last_row) state_d = DRAIN;
      // Stage 1 empty and the final result either gone or leaving this edge.
      DRAIN:    if (!s1_valid && (!res_valid || res_ready)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- vector store
  // Contents survive reset; vec_loaded alone says whether they are usable.
  always_ff @(posedge clk) begin
    if (vec_fire) vec_buf[vec_idx] <= vec_data;
  end

  // ---------------------------------------------------- job bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_idx    <= '0;
      vec_loaded <= 1'b0;
      rows_q     <= '0;
      row_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      if (job_start) begin
        rows_q   <= cfg_rows;
        row_cnt  <= '0;
        beat_cnt <= '0;
        vec_idx  <= '0;
        // A reload overwrites the buffer, so it stops being reusable
        // until the last element lands.
        if (state_d == LOAD_VEC) vec_loaded <= 1'b0;
      end
      if (vec_fire) begin
        vec_idx <= vec_idx + VIDX_W'(1);
        if (vec_idx == VIDX_W'(N - 1)) vec_loaded <= 1'b1;
      end
      if (mat_fire) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        if (last_beat) row_cnt <= row_cnt + CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------ lane products
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      mat_lane[j] = mat_data[j*DATA_W +: DATA_W];
      vec_op[j]   = vec_buf[VIDX_W'(int'(beat_cnt) * LANES + j)];
      prod[j]     = PROD_W'(mat_lane[j]) * PROD_W'(vec_op[j]);
    end
  end

  // ----------------------------------------------------------- stage 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= '0;
    end else if (en) begin
      s1_valid <= mat_fire;
      if (mat_fire) begin
        s1_first <= (beat_cnt == '0);
        s1_last  <= last_beat;
        s1_row   <= RROW_W'(row_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && mat_fire) begin
      for (int j = 0; j < LANES; j++) s1_prod[j] <= prod[j];
    end
  end

  // ----------------------------------------------------------- stage 2
  always_comb begin
    sum = '0;
    for (int j = 0; j < LANES; j++) sum = sum + ACC_W'(s1_prod[j]);
    acc_next = (s1_first ? '0 : acc) + sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
    end else begin
      if (en && s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          res_data <= acc_next;
          res_row  <= s1_row;
        end
      end
      // A new result loading on the handshake edge keeps valid high.
      if (en && s1_valid && s1_last) res_valid <= 1'b1;
      else if (res_ready)            res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gemv_mac_scheduler.sv
// Directed bench for gemv_mac_scheduler: one task per scenario, each with
// hand-computed expected results pushed into exp_q/exp_r.
module tb_gemv_mac_scheduler;
  localparam int DATA_W   = 16;
  localparam int N        = 32;
  localparam int LANES    = 4;
  localparam int ROWS_MAX = 64;
  localparam int ACC_W    = 40;
  localparam int BEATS    = N / LANES;
  localparam int LIMIT    = 500;

  // ------------------------------------------------- clock / reset / DUT
  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [6:0]              cfg_rows = '0;
  logic                    keep_vec = 1'b0;
  logic                    vec_valid = 1'b0;
  logic                    vec_ready;
  logic [DATA_W-1:0]       vec_data = '0;
  logic                    mat_valid = 1'b0;
  logic                    mat_ready;
  logic [LANES*DATA_W-1:0] mat_data = '0;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic [ACC_W-1:0]        res_data;
  logic [5:0]              res_row;
  logic                    busy;
  logic                    done;

  always #5 clk = ~clk;

  gemv_mac_scheduler #(
    .DATA_W(DATA_W), .N(N), .LANES(LANES), .ROWS_MAX(ROWS_MAX), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
    .keep_vec(keep_vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .mat_valid(mat_valid), .mat_ready(mat_ready),
    .mat_data(mat_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .busy(busy), .done(done)
  );

  // ------------------------------------------------------ stimulus data
  int vec_v [N];
  int mat_m [4][N];

  // --------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;
  logic [ACC_W-1:0] exp_q [$];
  logic [5:0]       exp_r [$];
  logic [ACC_W-1:0] got_d [$];
  logic [5:0]       got_r [$];

  int  cyc = 0;
  int  done_cnt, busy_cnt, vr_cnt, vacc_cnt, mr_cnt, macc_cnt;
  int  rv_cnt, stall_cnt, stall_mr, both_cnt;
  int  last_mat_cyc, first_rv_cyc;
  bit  hung;

  // Observation only: records handshakes and activity at the negedge.
  always @(negedge clk) begin
    cyc++;
    if (res_valid && res_ready) begin
      got_d.push_back(res_data);
      got_r.push_back(res_row);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (vec_ready) vr_cnt++;
    if (vec_valid && vec_ready) vacc_cnt++;
    if (mat_ready) mr_cnt++;
    if (mat_valid && mat_ready) begin macc_cnt++; last_mat_cyc = cyc; end
    if (res_valid) rv_cnt++;
    if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
    if (res_valid && !res_ready) stall_cnt++;
    if (res_valid && !res_ready && mat_ready) stall_mr++;
    if (vec_ready && mat_ready) both_cnt++;
  end

  task automatic clear_mon();
    done_cnt = 0; busy_cnt = 0; vr_cnt = 0; vacc_cnt = 0; mr_cnt = 0;
    macc_cnt = 0; rv_cnt = 0; stall_cnt = 0; stall_mr = 0; both_cnt = 0;
    last_mat_cyc = -1; first_rv_cyc = -1; hung = 1'b0;
    got_d.delete(); got_r.delete(); exp_q.delete(); exp_r.delete();
  endtask

  // ------------------------------------------------------- driver tasks
  // Holds the current beat until the matching ready is seen, bounded.
  task automatic wait_acc(input bit is_mat);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    if (hung) return;
    while (!ok && n < LIMIT) begin
      @(negedge clk);
      ok = is_mat ? mat_ready : vec_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      hung = 1'b1;
      total++; bad++;
      $display("FAIL handshake_timeout is_mat=%0d got=no_ready need=ready", is_mat);
    end
  endtask

  task automatic kick(input int rows, input bit keep);
    start = 1'b1; cfg_rows = 7'(rows); keep_vec = keep;
    @(posedge clk); #1;
    start = 1'b0; keep_vec = 1'b0;
  endtask

  task automatic feed(input int rows, input bit send_vec, input bit poke);
    if (send_vec) begin
      for (int i = 0; i < N; i++) begin
        vec_valid = 1'b1; vec_data = DATA_W'(vec_v[i]);
        wait_acc(1'b0);
      end
    end
    vec_valid = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < BEATS; b++) begin
        mat_valid = 1'b1;
        for (int j = 0; j < LANES; j++)
          mat_data[j*DATA_W +: DATA_W] = DATA_W'(mat_m[r][b*LANES+j]);
        if (poke && r == 0 && b == 2) begin start = 1'b1; cfg_rows = '0; end
        wait_acc(1'b1);
        start = 1'b0;
      end
    end
    mat_valid = 1'b0;
  endtask

  // With stall set, the first result is left waiting for 10 cycles.
  task automatic consume(input bit stall);
    int n;
    if (!stall) begin res_ready = 1'b1; return; end
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < LIMIT);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    res_ready = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < LIMIT) begin @(posedge clk); n++; end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout got=no_done need=done_pulse");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int rows, input bit keep, input bit send_vec,
                         input bit stall, input bit poke);
    res_ready = !stall;
    kick(rows, keep);
    fork
      feed(rows, send_vec, poke);
      consume(stall);
    join
    wait_done();
  endtask

  // ---------------------------------------------------------- scenarios
  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({vec_ready, mat_ready, res_valid, busy, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b need=00000",
               {vec_ready, mat_ready, res_valid, busy, done});
    end
    total++;
    if (res_data !== '0 || res_row !== '0) begin
      bad++;
      $display("FAIL reset_result got=%0h/%0d need=0/0", res_data, res_row);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_mon();
    for (int i = 0; i < N; i++) begin vec_v[i] = 1; mat_m[0][i] = 2; end
    exp_q.push_back(ACC_W'(64)); exp_r.push_back(6'd0);
    run_job(1, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (vacc_cnt !== 32) begin bad++; $display("FAIL basic_vec_beats got=%0d need=32", vacc_cnt); end
    total++;
    if (macc_cnt !== 8) begin bad++; $display("FAIL basic_mat_beats got=%0d need=8", macc_cnt); end
    total++;
    if (first_rv_cyc - last_mat_cyc !== 2) begin
      bad++;
      $display("FAIL basic_latency got=%0d need=2", first_rv_cyc - last_mat_cyc);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL basic_done got=%0d need=1", done_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b need=0", busy); end
    total++;
    if (got_d.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_count got=%0d need=%0d", got_d.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_d[k] !== exp_q[k] || got_r[k] !== exp_r[k]) begin
          bad++;
          $display("FAIL basic_res%0d got=%0d row%0d need=%0d row%0d", k,
                   $signed(got_d[k]), got_r[k], $signed(exp_q[k]), exp_r[k]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    // (-32768)*(-32768)*32 = 2^35
    clear_mon();
    for (int i = 0; i < N; i++) begin vec_v[i] = -32768; mat_m[0][i] = -32768; end
    exp_q.push_back(ACC_W'(64'sd34359738368)); exp_r.push_back(6'd0);
    run_job(1, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (got_d.size() != 1) begin
      bad++; $display("FAIL extreme_neg_count got=%0d need=1", got_d.size());
    end else begin
      total++;
      if (got_d[0] !== exp_q[0] || got_r[0] !== exp_r[0]) begin
        bad++;
        $display("FAIL extreme_neg got=%0d row%0d need=%0d row0",
                 $signed(got_d[0]), got_r[0], $signed(exp_q[0]));
      end
    end
    // (-32768)*32767*32 = -34358689792, vector reused
    clear_mon();
    for (int i = 0; i < N; i++) mat_m[0][i] = 32767;
    exp_q.push_back(ACC_W'(-64'sd34358689792)); exp_r.push_back(6'd0);
    run_job(1, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (got_d.size() != 1) begin
      bad++; $display("FAIL extreme_mix_count got=%0d need=1", got_d.size());
    end else begin
      total++;
      if (got_d[0] !== exp_q[0] || got_r[0] !== exp_r[0]) begin
        bad++;
        $display("FAIL extreme_mix got=%0d row%0d need=%0d row0",
                 $signed(got_d[0]), got_r[0], $signed(exp_q[0]));
      end
    end
  endtask

  task automatic test_lane_order();
    // vec[i]=i. Row 0: e9=1, e30=-2 -> 9-60=-51. Row 1: e4=7, e31=1 -> 28+31=59.
    clear_mon();
    for (int i = 0; i < N; i++) begin vec_v[i] = i; mat_m[0][i] = 0; mat_m[1][i] = 0; end
    mat_m[0][9] = 1; mat_m[0][30] = -2; mat_m[1][4] = 7; mat_m[1][31] = 1;
    exp_q.push_back(ACC_W'(-51)); exp_r.push_back(6'd0);
    exp_q.push_back(ACC_W'(59));  exp_r.push_back(6'd1);
    run_job(2, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (got_d.size() != exp_q.size()) begin
      bad++; $display("FAIL lane_count got=%0d need=%0d", got_d.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_d[k] !== exp_q[k] || got_r[k] !== exp_r[k]) begin
          bad++;
          $display("FAIL lane_res%0d got=%0d row%0d need=%0d row%0d", k,
                   $signed(got_d[k]), got_r[k], $signed(exp_q[k]), exp_r[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    // sum(0..31)=496, row r scaled by r+1
    clear_mon();
    for (int i = 0; i < N; i++) begin
      vec_v[i] = i;
      for (int r = 0; r < 3; r++) mat_m[r][i] = r + 1;
    end
    exp_q = '{40'd496, 40'd992, 40'd1488};
    exp_r = '{6'd0, 6'd1, 6'd2};
    run_job(3, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (stall_cnt !== 10) begin bad++; $display("FAIL bp_stall_cycles got=%0d need=10", stall_cnt); end
    total++;
    if (stall_mr !== 0) begin bad++; $display("FAIL bp_mat_ready_in_stall got=%0d need=0", stall_mr); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL bp_done got=%0d need=1", done_cnt); end
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL bp_both_ready got=%0d need=0", both_cnt); end
    total++;
    if (got_d.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_count got=%0d need=%0d", got_d.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_d[k] !== exp_q[k] || got_r[k] !== exp_r[k]) begin
          bad++;
          $display("FAIL bp_res%0d got=%0d row%0d need=%0d row%0d", k,
                   $signed(got_d[k]), got_r[k], $signed(exp_q[k]), exp_r[k]);
        end
      end
    end
  endtask

  task automatic test_keep_vec();
    clear_mon();
    exp_q = '{40'd496, 40'd992, 40'd1488};
    exp_r = '{6'd0, 6'd1, 6'd2};
    run_job(3, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (vr_cnt !== 0) begin bad++; $display("FAIL keep_vec_ready got=%0d need=0", vr_cnt); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL keep_done got=%0d need=1", done_cnt); end
    total++;
    if (got_d.size() != exp_q.size()) begin
      bad++; $display("FAIL keep_count got=%0d need=%0d", got_d.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (got_d[k] !== exp_q[k] || got_r[k] !== exp_r[k]) begin
          bad++;
          $display("FAIL keep_res%0d got=%0d row%0d need=%0d row%0d", k,
                   $signed(got_d[k]), got_r[k], $signed(exp_q[k]), exp_r[k]);
        end
      end
    end
  endtask

  task automatic test_zero_rows();
    clear_mon();
    res_ready = 1'b1;
    kick(0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy_cnt !== 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d need=1", busy_cnt); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL zero_done got=%0d need=1", done_cnt); end
    total++;
    if (vr_cnt + mr_cnt + rv_cnt !== 0) begin
      bad++;
      $display("FAIL zero_activity got=vr%0d/mr%0d/rv%0d need=0/0/0", vr_cnt, mr_cnt, rv_cnt);
    end
  endtask

  task automatic test_start_ignored();
    // Stored vector is 0..31, row all 2 -> 992. A start with cfg_rows=0
    // arrives during the row and must not end the job.
    clear_mon();
    for (int i = 0; i < N; i++) mat_m[0][i] = 2;
    run_job(1, 1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done got=%0d need=1", done_cnt); end
    total++;
    if (got_d.size() != 1) begin
      bad++; $display("FAIL ignore_count got=%0d need=1", got_d.size());
    end else begin
      total++;
      if (got_d[0] !== 40'd992 || got_r[0] !== 6'd0) begin
        bad++;
        $display("FAIL ignore_res got=%0d row%0d need=992 row0", $signed(got_d[0]), got_r[0]);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    clear_mon();
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin vec_v[i] = 1; mat_m[0][i] = 2; end
    kick(1, 1'b0);
    for (int i = 0; i < N; i++) begin
      vec_valid = 1'b1; vec_data = DATA_W'(vec_v[i]);
      wait_acc(1'b0);
    end
    vec_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mat_valid = 1'b1;
      for (int j = 0; j < LANES; j++)
        mat_data[j*DATA_W +: DATA_W] = DATA_W'(mat_m[0][b*LANES+j]);
      wait_acc(1'b1);
    end
    mat_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({vec_ready, mat_ready, res_valid, busy, done} !== 5'b0 ||
        res_data !== '0 || res_row !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b/%0h/%0d need=00000/0/0",
               {vec_ready, mat_ready, res_valid, busy, done}, res_data, res_row);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (got_d.size() !== 0 || done_cnt !== 0) begin
      bad++;
      $display("FAIL midreset_abandon got=res%0d/done%0d need=0/0", got_d.size(), done_cnt);
    end
    // vec_loaded was cleared, so keep_vec must fall back to loading.
    kick(1, 1'b1);
    @(negedge clk);
    total++;
    if (vec_ready !== 1'b1) begin bad++; $display("FAIL midreset_reload got=%b need=1", vec_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin vec_v[i] = 3; mat_m[0][i] = 1; end
    feed(1, 1'b1, 1'b0);
    wait_done();
    total++;
    if (got_d.size() != 1) begin
      bad++; $display("FAIL midreset_count got=%0d need=1", got_d.size());
    end else begin
      total++;
      if (got_d[0] !== 40'd96 || got_r[0] !== 6'd0) begin
        bad++;
        $display("FAIL midreset_res got=%0d row%0d need=96 row0", $signed(got_d[0]), got_r[0]);
      end
    end
  endtask

  // ------------------------------------------------------------- report
  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_extremes();
    test_lane_order();
    test_backpressure();
    test_keep_vec();
    test_zero_rows();
    test_start_ignored();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
